// File: rtl/thor2021_mcop_ctrl_pkg.sv
// rtl/thor2021_mcop_ctrl_pkg.sv - shared types and constants for the Thor2021 multi-cycle op sequencer
package thor2021_mcop_ctrl_pkg;

  // Sequencer states: waiting for an op, multiply in progress, divide in progress, writeback strobe
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    WB   = 2'd3
  } mcop_state_t;

  // Operand signedness encodings shared with the multiplier and divider
  localparam logic [1:0] MC_UNS = 2'b00;
  localparam logic [1:0] MC_SGN = 2'b01;
  localparam logic [1:0] MC_SU  = 2'b10;

endpackage

// File: rtl/thor2021_mcop_ctrl.sv
// rtl/thor2021_mcop_ctrl.sv - sequencer for multi-cycle multiply/divide with stall and writeback strobe
module thor2021_mcop_ctrl
  import thor2021_mcop_ctrl_pkg::*;
#(
  parameter int WID         = 64,
  parameter int MUL_LAT     = 3,
  parameter int DIV_TIMEOUT = 80
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             issue_i,
  input  logic             mulall_i,
  input  logic             divall_i,
  input  logic [1:0]       sgn_i,
  input  logic             hi_i,
  input  logic             useimm_i,
  input  logic [WID-1:0]   a_i,
  input  logic [WID-1:0]   b_i,
  input  logic [WID-1:0]   imm_i,
  input  logic [5:0]       Rt_i,
  output logic             busy_o,
  output logic             mul_ld_o,
  output logic [WID-1:0]   mul_a_o,
  output logic [WID-1:0]   mul_b_o,
  output logic [1:0]       mul_sgn_o,
  input  logic [2*WID-1:0] mul_prod_i,
  output logic             div_ld_o,
  output logic [WID-1:0]   div_a_o,
  output logic [WID-1:0]   div_b_o,
  output logic [1:0]       div_sgn_o,
  input  logic             div_done_i,
  input  logic [WID-1:0]   div_q_i,
  output logic             res_v_o,
  output logic [WID-1:0]   res_o,
  output logic [5:0]       res_Rt_o,
  output logic             dbz_o,
  output logic             tmo_o
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  mcop_state_t    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           first_q, first_d;
  logic [WID-1:0] a_q, a_d;
  logic [WID-1:0] b_q, b_d;
  logic [1:0]     sgn_q, sgn_d;
  logic           hi_q, hi_d;
  logic [5:0]     rt_q, rt_d;
  logic [WID-1:0] res_q, res_d;
  logic           dbz_q, dbz_d;
  logic           tmo_q, tmo_d;
  logic           mul_ld, div_ld;
  logic [WID-1:0] b_eff;
  logic           accept;

  assign b_eff  = useimm_i ? imm_i : b_i;
  // Exactly one of multiply/divide must be flagged; flush always wins over a new issue
  assign accept = issue_i && !flush_i && (mulall_i ^ divall_i);

  // Next-state, counter and operand/result capture; flush overrides everything at the end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    rt_d    = rt_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    tmo_d   = tmo_q;
    mul_ld  = 1'b0;
    div_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a_i;
          b_d     = b_eff;
          sgn_d   = sgn_i;
          hi_d    = hi_i;
          rt_d    = Rt_i;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          tmo_d   = 1'b0;
          first_d = 1'b1;
          if (mulall_i) begin
            state_d = MUL;
          end else if (b_eff == '0) begin
            // Divide by zero never reaches the divider
            res_d   = '1;
            dbz_d   = 1'b1;
            first_d = 1'b0;
            state_d = WB;
          end else begin
            state_d = DIV;
          end
        end
      end
      MUL: begin
        if (first_q) begin
          // Count starts at the load pulse so capture lands MUL_LAT cycles later
          mul_ld  = 1'b1;
          first_d = 1'b0;
          cnt_d   = CW'(MUL_LAT - 1);
        end else if (cnt_q == '0) begin
          res_d   = hi_q ? mul_prod_i[2*WID-1:WID] : mul_prod_i[WID-1:0];
          state_d = WB;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV: begin
        div_ld  = first_q;
        first_d = 1'b0;
        if (div_done_i) begin
          res_d   = div_q_i;
          state_d = WB;
        end else if (cnt_q == CW'(DIV_TIMEOUT - 1)) begin
          res_d   = '0;
          tmo_d   = 1'b1;
          state_d = WB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush_i) begin
      state_d = IDLE;
      first_d = 1'b0;
      mul_ld  = 1'b0;
      div_ld  = 1'b0;
    end
  end

  // State, counter and latched operands/results
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= MC_UNS;
      hi_q    <= 1'b0;
      rt_q    <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      rt_q    <= rt_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign mul_ld_o  = mul_ld;
  assign div_ld_o  = div_ld;
  assign mul_a_o   = a_q;
  assign mul_b_o   = b_q;
  assign mul_sgn_o = sgn_q;
  assign div_a_o   = a_q;
  assign div_b_o   = b_q;
  assign div_sgn_o = sgn_q;
  assign res_v_o   = (state_q == WB);
  assign res_o     = res_q;
  assign res_Rt_o  = rt_q;
  assign dbz_o     = (state_q == WB) && dbz_q;
  assign tmo_o     = (state_q == WB) && tmo_q;

endmodule

// File: tb/tb_thor2021_mcop_ctrl.sv
// tb/tb_thor2021_mcop_ctrl.sv - directed self-checking bench for thor2021_mcop_ctrl
module tb_thor2021_mcop_ctrl;

  localparam int WID = 64;
  localparam int MUL_LAT = 3;
  localparam int DIV_TIMEOUT = 80;

  logic             clk;
  logic             rst_n;
  logic             flush, issue, mulall, divall, hi, useimm;
  logic [1:0]       sgn;
  logic [WID-1:0]   a, b, imm;
  logic [5:0]       rt;
  logic             busy, mul_ld, div_ld, div_done, res_v, dbz, tmo;
  logic [WID-1:0]   mul_a, mul_b, div_a, div_b, div_q, res;
  logic [1:0]       mul_sgn, div_sgn;
  logic [2*WID-1:0] mul_prod;
  logic [5:0]       res_rt;

  int checks = 0;
  int errors = 0;

  thor2021_mcop_ctrl #(.WID(WID), .MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .issue_i(issue),
    .mulall_i(mulall), .divall_i(divall), .sgn_i(sgn), .hi_i(hi), .useimm_i(useimm),
    .a_i(a), .b_i(b), .imm_i(imm), .Rt_i(rt), .busy_o(busy),
    .mul_ld_o(mul_ld), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_sgn_o(mul_sgn),
    .mul_prod_i(mul_prod), .div_ld_o(div_ld), .div_a_o(div_a), .div_b_o(div_b),
    .div_sgn_o(div_sgn), .div_done_i(div_done), .div_q_i(div_q),
    .res_v_o(res_v), .res_o(res), .res_Rt_o(res_rt), .dbz_o(dbz), .tmo_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in multiplier: product appears MUL_LAT cycles after the load cycle, junk otherwise
  logic [MUL_LAT-1:0] mvld;
  logic [2*WID-1:0]   mprod;
  always @(posedge clk) begin
    if (!rst_n) begin
      mvld <= '0;
    end else begin
      mvld <= {mvld[MUL_LAT-2:0], mul_ld};
      if (mul_ld) begin
        mprod <= (mul_sgn[0] | mul_sgn[1] ? {{WID{mul_a[WID-1]}}, mul_a} : {{WID{1'b0}}, mul_a}) *
                 (mul_sgn == 2'b01 ? {{WID{mul_b[WID-1]}}, mul_b} : {{WID{1'b0}}, mul_b});
      end
    end
  end
  assign mul_prod = mvld[MUL_LAT-1] ? mprod : {4{32'h5A5A_C3C3}};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    issue = 0; mulall = 0; divall = 0; sgn = 2'b00; hi = 0; useimm = 0;
    a = '0; b = '0; imm = '0; rt = '0; div_done = 0; div_q = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic put_op(input logic m, input logic d, input logic [1:0] s, input logic h,
                        input logic ui, input logic [WID-1:0] av, input logic [WID-1:0] bv,
                        input logic [WID-1:0] iv, input logic [5:0] r);
    issue = 1; mulall = m; divall = d; sgn = s; hi = h; useimm = ui;
    a = av; b = bv; imm = iv; rt = r;
  endtask

  int vcyc, vcnt, ldcnt;

  initial begin
    idle_inputs();
    flush = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_res_v", res_v, 0);
    check_eq("rst_mul_ld", mul_ld, 0);
    check_eq("rst_div_ld", div_ld, 0);
    check_eq("rst_res", res, 0);
    check_eq("rst_rt", res_rt, 0);
    check_eq("rst_flags", {dbz, tmo}, 0);
    check_eq("rst_mul_a", mul_a, 0);
    rst_n = 1;

    // 1: signed MUL -3*7, writeback in cycle 5
    tick();
    put_op(1, 0, 2'b01, 0, 0, -64'sd3, 64'd7, 64'd0, 6'd5);
    settle();
    check_eq("t1_busy_c0", busy, 0);
    for (int c = 1; c <= 6; c++) begin
      tick(); idle_inputs(); settle();
      check_eq($sformatf("t1_mul_ld_c%0d", c), mul_ld, c == 1);
      check_eq($sformatf("t1_res_v_c%0d", c), res_v, c == 5);
      check_eq($sformatf("t1_busy_c%0d", c), busy, c <= 5);
      if (c == 5) begin
        check_eq("t1_res", res, 64'hFFFF_FFFF_FFFF_FFEB);
        check_eq("t1_rt", res_rt, 6'd5);
        check_eq("t1_dbz", dbz, 0);
      end
    end

    // 2: MULHU all-ones squared, high half
    tick();
    put_op(1, 0, 2'b00, 1, 0, '1, '1, 64'd0, 6'd9);
    for (int c = 1; c <= 5; c++) begin
      tick(); idle_inputs(); settle();
      check_eq($sformatf("t2_res_v_c%0d", c), res_v, c == 5);
      if (c == 5) check_eq("t2_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
    end

    // 3a: DIVI 100/7, done ten cycles after load
    tick();
    put_op(0, 1, 2'b01, 0, 1, 64'd100, 64'd999, 64'd7, 6'd12);
    for (int c = 1; c <= 12; c++) begin
      tick(); idle_inputs();
      if (c == 11) begin div_done = 1; div_q = 64'd14; end
      settle();
      check_eq($sformatf("t3_div_ld_c%0d", c), div_ld, c == 1);
      check_eq($sformatf("t3_res_v_c%0d", c), res_v, c == 12);
      if (c == 1) check_eq("t3_div_ops", {div_a, div_b}, {64'd100, 64'd7});
      if (c == 12) check_eq("t3_res", {res, 6'(res_rt), dbz}, {64'd14, 6'd12, 1'b0});
    end

    // 3b: divide by zero, writeback in cycle 1, divider untouched
    tick();
    put_op(0, 1, 2'b00, 0, 0, 64'd55, 64'd0, 64'd0, 6'd3);
    settle();
    check_eq("t3z_div_ld_c0", div_ld, 0);
    tick(); idle_inputs(); settle();
    check_eq("t3z_div_ld_c1", div_ld, 0);
    check_eq("t3z_res_v_c1", res_v, 1);
    check_eq("t3z_res", {res, dbz, tmo}, {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
    tick(); settle();
    check_eq("t3z_res_v_c2", {res_v, busy, dbz}, 0);

    // 4: divider never finishes -> timeout writeback DIV_TIMEOUT+1 cycles after accept
    tick();
    put_op(0, 1, 2'b00, 0, 0, 64'd5, 64'd3, 64'd0, 6'd1);
    vcyc = -1; vcnt = 0; ldcnt = 0;
    for (int c = 1; c <= DIV_TIMEOUT + 3; c++) begin
      tick(); idle_inputs(); settle();
      if (div_ld) ldcnt++;
      if (res_v) begin
        vcnt++; vcyc = c;
        check_eq("t4_res", {res, dbz, tmo}, {64'd0, 1'b0, 1'b1});
      end
    end
    check_eq("t4_res_v_cycle", 32'(vcyc), DIV_TIMEOUT + 1);
    check_eq("t4_res_v_count", 32'(vcnt), 1);
    check_eq("t4_ld_count", 32'(ldcnt), 1);

    // 5a: flush in MUL cycle 2, new MUL accepted right after
    tick();
    put_op(1, 0, 2'b00, 0, 0, 64'd2, 64'd3, 64'd0, 6'd4);
    tick(); idle_inputs(); settle();
    check_eq("t5_mul_ld_c1", mul_ld, 1);
    tick(); flush = 1; settle();
    check_eq("t5_flush_c2", {res_v, mul_ld}, 0);
    tick(); flush = 0; settle();
    check_eq("t5_busy_c3", busy, 0);
    put_op(1, 0, 2'b00, 0, 0, 64'd6, 64'd7, 64'd0, 6'd8);
    vcnt = 0;
    for (int c = 1; c <= 6; c++) begin
      tick(); idle_inputs(); settle();
      if (res_v) vcnt++;
      check_eq($sformatf("t5_res_v_c%0d", c), res_v, c == 5);
      if (c == 5) check_eq("t5_res", {res, 6'(res_rt)}, {64'd42, 6'd8});
    end
    check_eq("t5_res_v_count", 32'(vcnt), 1);

    // 5b: flush during DIV, stale done afterwards is ignored
    tick();
    put_op(0, 1, 2'b00, 0, 0, 64'd50, 64'd5, 64'd0, 6'd2);
    tick(); idle_inputs(); settle();
    check_eq("t5d_div_ld_c1", div_ld, 1);
    tick(); settle();
    tick(); flush = 1; settle();
    tick(); flush = 0; settle();
    check_eq("t5d_busy_c4", busy, 0);
    vcnt = 0;
    for (int c = 5; c <= 8; c++) begin
      tick(); idle_inputs();
      if (c == 5) begin div_done = 1; div_q = 64'd10; end
      settle();
      if (res_v || busy) vcnt++;
    end
    check_eq("t5d_stale_done", 32'(vcnt), 0);

    // 6a: both multiply and divide flagged -> ignored
    tick();
    put_op(1, 1, 2'b00, 0, 0, 64'd1, 64'd1, 64'd0, 6'd1);
    tick(); idle_inputs(); settle();
    check_eq("t6_both_ignored", {busy, mul_ld, div_ld}, 0);

    // 6b: issue with simultaneous flush -> ignored
    tick();
    put_op(1, 0, 2'b00, 0, 0, 64'd1, 64'd1, 64'd0, 6'd1);
    flush = 1;
    tick(); idle_inputs(); flush = 0; settle();
    check_eq("t6_flush_issue", {busy, mul_ld}, 0);

    // 6c: asynchronous reset in the middle of a divide
    tick();
    put_op(0, 1, 2'b00, 0, 0, 64'd9, 64'd3, 64'd0, 6'd7);
    tick(); idle_inputs(); settle();
    tick(); settle();
    check_eq("t6_busy_pre_rst", busy, 1);
    rst_n = 0;
    #1;
    check_eq("t6_rst_outputs", {busy, res_v, div_ld, div_a, 6'(res_rt)}, 0);
    tick(); rst_n = 1;
    vcnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick(); settle();
      if (res_v || busy) vcnt++;
    end
    check_eq("t6_no_wb_after_rst", 32'(vcnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
